// File: rtl/ps2_keymap_pkg.sv
// Shared types and scan-code constants for the PS/2 key mapper.
package ps2_keymap_pkg;

   localparam int unsigned NOTE_W = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned KEY_W  = 9;

   typedef enum logic [1:0] {IDLE, EXT, BREAK, EXT_BREAK} state_t;

   typedef enum logic [3:0] {
      KEY_NONE, KEY_NOTE, KEY_OCT_INC, KEY_OCT_DEC, KEY_AMP_INC,
      KEY_AMP_DEC, KEY_ADSR_SEL, KEY_ADSR_INC, KEY_ADSR_DEC
   } key_class_t;

   // value carries the semitone index for notes or the selector for ADSR select
   typedef struct packed {
      key_class_t        kclass;
      logic [NOTE_W-1:0] value;
   } key_info_t;

   localparam logic [7:0] PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PREFIX_BREAK = 8'hF0;

   localparam logic [7:0] SC_NOTE_C  = 8'h1C;
   localparam logic [7:0] SC_NOTE_CS = 8'h1D;
   localparam logic [7:0] SC_NOTE_D  = 8'h1B;
   localparam logic [7:0] SC_NOTE_DS = 8'h24;
   localparam logic [7:0] SC_NOTE_E  = 8'h23;
   localparam logic [7:0] SC_NOTE_F  = 8'h2B;
   localparam logic [7:0] SC_NOTE_FS = 8'h2C;
   localparam logic [7:0] SC_NOTE_G  = 8'h34;
   localparam logic [7:0] SC_NOTE_GS = 8'h35;
   localparam logic [7:0] SC_NOTE_A  = 8'h33;
   localparam logic [7:0] SC_NOTE_AS = 8'h3C;
   localparam logic [7:0] SC_NOTE_B  = 8'h3B;

   localparam logic [7:0] SC_OCT_DEC  = 8'h1A;
   localparam logic [7:0] SC_OCT_INC  = 8'h22;
   localparam logic [7:0] SC_AMP_DEC  = 8'h4E;
   localparam logic [7:0] SC_AMP_INC  = 8'h55;
   localparam logic [7:0] SC_ADSR_ATK = 8'h16;
   localparam logic [7:0] SC_ADSR_DCY = 8'h1E;
   localparam logic [7:0] SC_ADSR_SUS = 8'h26;
   localparam logic [7:0] SC_ADSR_REL = 8'h25;
   localparam logic [7:0] SC_ADSR_DEC = 8'h41;
   localparam logic [7:0] SC_ADSR_INC = 8'h49;

   localparam logic [7:0] SC_X_AMP_INC = 8'h75;
   localparam logic [7:0] SC_X_AMP_DEC = 8'h72;
   localparam logic [7:0] SC_X_OCT_DEC = 8'h6B;
   localparam logic [7:0] SC_X_OCT_INC = 8'h74;

endpackage

// File: rtl/ps2_scancode_lut.sv
// Combinational classification of a scan code (with extended flag) into a key class and value.
module ps2_scancode_lut
   import ps2_keymap_pkg::*;
(
   input  logic      ext,
   input  logic [7:0] scan_code,
   output key_info_t key_info
);

   always_comb begin
      key_info.kclass = KEY_NONE;
      key_info.value  = '0;
      if (!ext) begin
         case (scan_code)
            SC_NOTE_C:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd0;  end
            SC_NOTE_CS:  begin key_info.kclass = KEY_NOTE; key_info.value = 4'd1;  end
            SC_NOTE_D:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd2;  end
            SC_NOTE_DS:  begin key_info.kclass = KEY_NOTE; key_info.value = 4'd3;  end
            SC_NOTE_E:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd4;  end
            SC_NOTE_F:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd5;  end
            SC_NOTE_FS:  begin key_info.kclass = KEY_NOTE; key_info.value = 4'd6;  end
            SC_NOTE_G:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd7;  end
            SC_NOTE_GS:  begin key_info.kclass = KEY_NOTE; key_info.value = 4'd8;  end
            SC_NOTE_A:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd9;  end
            SC_NOTE_AS:  begin key_info.kclass = KEY_NOTE; key_info.value = 4'd10; end
            SC_NOTE_B:   begin key_info.kclass = KEY_NOTE; key_info.value = 4'd11; end
            SC_OCT_DEC:  key_info.kclass = KEY_OCT_DEC;
            SC_OCT_INC:  key_info.kclass = KEY_OCT_INC;
            SC_AMP_DEC:  key_info.kclass = KEY_AMP_DEC;
            SC_AMP_INC:  key_info.kclass = KEY_AMP_INC;
            SC_ADSR_ATK: begin key_info.kclass = KEY_ADSR_SEL; key_info.value = 4'd0; end
            SC_ADSR_DCY: begin key_info.kclass = KEY_ADSR_SEL; key_info.value = 4'd1; end
            SC_ADSR_SUS: begin key_info.kclass = KEY_ADSR_SEL; key_info.value = 4'd2; end
            SC_ADSR_REL: begin key_info.kclass = KEY_ADSR_SEL; key_info.value = 4'd3; end
            SC_ADSR_DEC: key_info.kclass = KEY_ADSR_DEC;
            SC_ADSR_INC: key_info.kclass = KEY_ADSR_INC;
            default: ;
         endcase
      end else begin
         case (scan_code)
            SC_X_AMP_INC: key_info.kclass = KEY_AMP_INC;
            SC_X_AMP_DEC: key_info.kclass = KEY_AMP_DEC;
            SC_X_OCT_DEC: key_info.kclass = KEY_OCT_DEC;
            SC_X_OCT_INC: key_info.kclass = KEY_OCT_INC;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_mapper.sv
// Turns PS/2 scan-code bytes into a last-note gate/index and one-cycle control pulses.
module ps2_key_mapper
   import ps2_keymap_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        ps2_byte,
   input  logic              ps2_byte_valid,
   output logic              note_in,
   output logic [NOTE_W-1:0] note,
   output logic              octave_inc,
   output logic              octave_dec,
   output logic              amp_inc,
   output logic              amp_dec,
   output logic [SEL_W-1:0]  adsr_sel,
   output logic              adsr_inc,
   output logic              adsr_dec
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [KEY_W-1:0]   held_key, held_key_n;
   logic               note_in_n;
   logic [NOTE_W-1:0]  note_n;
   logic [SEL_W-1:0]   adsr_sel_n;
   logic               octave_inc_n, octave_dec_n, amp_inc_n, amp_dec_n;
   logic               adsr_inc_n, adsr_dec_n;
   logic               do_make, do_break;
   logic               lut_ext;
   logic [KEY_W-1:0]   cur_key;
   key_info_t          key_info;

   // The extended flag for classification comes from the prefix already seen
   assign lut_ext = (state == EXT) || (state == EXT_BREAK);
   assign cur_key = {lut_ext, ps2_byte};

   ps2_scancode_lut u_lut (
      .ext       (lut_ext),
      .scan_code (ps2_byte),
      .key_info  (key_info)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         held_key   <= '0;
         note_in    <= 1'b0;
         note       <= '0;
         adsr_sel   <= '0;
         octave_inc <= 1'b0;
         octave_dec <= 1'b0;
         amp_inc    <= 1'b0;
         amp_dec    <= 1'b0;
         adsr_inc   <= 1'b0;
         adsr_dec   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         held_key   <= held_key_n;
         note_in    <= note_in_n;
         note       <= note_n;
         adsr_sel   <= adsr_sel_n;
         octave_inc <= octave_inc_n;
         octave_dec <= octave_dec_n;
         amp_inc    <= amp_inc_n;
         amp_dec    <= amp_dec_n;
         adsr_inc   <= adsr_inc_n;
         adsr_dec   <= adsr_dec_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      held_key_n   = held_key;
      note_in_n    = note_in;
      note_n       = note;
      adsr_sel_n   = adsr_sel;
      octave_inc_n = 1'b0;
      octave_dec_n = 1'b0;
      amp_inc_n    = 1'b0;
      amp_dec_n    = 1'b0;
      adsr_inc_n   = 1'b0;
      adsr_dec_n   = 1'b0;
      do_make      = 1'b0;
      do_break     = 1'b0;

      // A valid byte always takes priority over an expiring prefix timeout
      if (ps2_byte_valid) begin
         cnt_n = '0;
         case (state)
            IDLE: begin
               if (ps2_byte == PREFIX_EXT)        state_n = EXT;
               else if (ps2_byte == PREFIX_BREAK) state_n = BREAK;
               else                               do_make = 1'b1;
            end
            EXT: begin
               if (ps2_byte == PREFIX_BREAK)    state_n = EXT_BREAK;
               else if (ps2_byte == PREFIX_EXT) state_n = EXT;
               else begin
                  do_make = 1'b1;
                  state_n = IDLE;
               end
            end
            BREAK: begin
               if (ps2_byte == PREFIX_EXT) state_n = EXT;
               else begin
                  do_break = 1'b1;
                  state_n  = IDLE;
               end
            end
            EXT_BREAK: begin
               do_break = 1'b1;
               state_n  = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE) begin
         if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end

      if (do_make) begin
         case (key_info.kclass)
            KEY_NOTE: begin
               note_n     = key_info.value;
               note_in_n  = 1'b1;
               held_key_n = cur_key;
            end
            KEY_OCT_INC:  octave_inc_n = 1'b1;
            KEY_OCT_DEC:  octave_dec_n = 1'b1;
            KEY_AMP_INC:  amp_inc_n    = 1'b1;
            KEY_AMP_DEC:  amp_dec_n    = 1'b1;
            KEY_ADSR_SEL: adsr_sel_n   = key_info.value[SEL_W-1:0];
            KEY_ADSR_INC: adsr_inc_n   = 1'b1;
            KEY_ADSR_DEC: adsr_dec_n   = 1'b1;
            default: ;
         endcase
      end

      // Only releasing the currently held note closes the gate
      if (do_break && (key_info.kclass == KEY_NOTE) && (cur_key == held_key)) begin
         note_in_n = 1'b0;
      end
   end

endmodule
